search_block_fetch: RTL

Upstream feeder for `top3DRS`. Reads one 16×16 pixel block from an external 8-bit frame memory and packs it into the 64-bit column-half words that the estimator's current-block and search-block buffers accept. In search mode, it offsets the block by a candidate motion vector and mirror-pads at the frame edges (36-pixel virtual border), so no padded frame copy is needed. It replaces the fetch loops that currently live in the bench, and answers `search_WE_req` / `curfilled`-style requests.

---
 rtl/me3drs_pkg.sv | 56 +++++
 rtl/search_block_fetch_if.sv | 35 +++
 rtl/mirror_fold.sv | 31 +++
 rtl/search_block_fetch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/me3drs_pkg.sv
// Shared definitions for the 3DRS motion-estimator feeder blocks.
// Holds frame geometry, block counts, the signed motion-vector type,
// the estimator buffer word-address layout, the fetch FSM state
// encoding and small helper functions used by search_block_fetch.
package me3drs_pkg;

  localparam int IMGWIDTH  = 1280;
  localparam int IMGHEIGHT = 720;
  localparam int PAD       = 36;
  localparam int BLK       = 16;
  localparam int BLKS_X    = IMGWIDTH / BLK;   // 80 blocks per row
  localparam int BLKS_Y    = IMGHEIGHT / BLK;  // 45 blocks per column

  // Signed coordinate width: covers -PAD .. IMGWIDTH-1+PAD
  localparam int CW = 12;

  // Signed two's-complement candidate vector component
  typedef logic signed [6:0] mv_t;

  localparam mv_t MV_MAX = 7'sd36;
  localparam mv_t MV_MIN = 7'sh5C;  // -36

  // data_addr = {column[3:0], half}
  localparam int DADDR_W        = 5;
  localparam int DADDR_HALF_BIT = 0;
  localparam int DADDR_COL_LSB  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Clamp a vector component to [-PAD, +PAD]
  function automatic mv_t clamp_mv(input mv_t v);
    mv_t r;
    if (v > MV_MAX) begin
      r = MV_MAX;
    end else if (v < MV_MIN) begin
      r = MV_MIN;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Build an estimator buffer word address from column and half
  function automatic logic [DADDR_W-1:0] make_data_addr(input logic [3:0] col,
                                                        input logic       half);
    logic [DADDR_W-1:0] r;
    r = {col, half};
    return r;
  endfunction

endpackage

// File: rtl/search_block_fetch_if.sv
// Bundle of request, frame-memory and estimator-buffer signals of
// search_block_fetch.
//   slave  : the fetch block (takes requests, drives memory reads and
//            buffer writes, receives read data)
//   master : requester / frame memory / estimator side
interface search_block_fetch_if;
  import me3drs_pkg::*;

  logic        start;
  logic        search_mode;
  logic [6:0]  blk_x;
  logic [5:0]  blk_y;
  mv_t         mv_x;
  mv_t         mv_y;
  logic        mem_rd_en;
  logic [19:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        data_we;
  logic [4:0]  data_addr;
  logic [63:0] data_out;
  logic        busy;
  logic        done;
  logic        err;

  modport slave (
    input  start, search_mode, blk_x, blk_y, mv_x, mv_y, mem_rdata,
    output mem_rd_en, mem_addr, data_we, data_addr, data_out, busy, done, err
  );

  modport master (
    output start, search_mode, blk_x, blk_y, mv_x, mv_y, mem_rdata,
    input  mem_rd_en, mem_addr, data_we, data_addr, data_out, busy, done, err
  );

endinterface

// File: rtl/mirror_fold.sv
// Combinational mirror fold of a signed coordinate into 0..n-1.
//   coord  : signed coordinate, at most n away from the valid range
//   n      : axis length
//   folded : v<0 -> -1-v ; v>=n -> 2n-1-v ; else v
module mirror_fold #(
  parameter int W = 12
) (
  input  logic signed [W-1:0] coord,
  input  logic        [W-1:0] n,
  output logic        [W-1:0] folded
);

  logic signed [W:0] v_s;
  logic signed [W:0] n_s;
  logic signed [W:0] res_s;

  // Reflect about -0.5 or n-0.5; ~v is -1-v in two's complement
  always_comb begin
    v_s = {coord[W-1], coord};
    n_s = {1'b0, n};
    if (v_s[W]) begin
      res_s = ~v_s;
    end else if (v_s >= n_s) begin
      res_s = n_s + n_s + ~v_s;
    end else begin
      res_s = v_s;
    end
    folded = res_s[W-1:0];
  end

endmodule

// File: rtl/search_block_fetch.sv
// Fetches one 16x16 block from 8-bit frame memory and packs it into
// 64-bit column-half words for the estimator block buffers. In search
// mode the block is offset by a clamped candidate vector and mirror
// padded at frame edges.
//   clk   : rising-edge clock
//   reset : synchronous, active low
//   bus   : request inputs, frame-memory read port, buffer write port,
//           busy/done/err status
// Reads go column-major (column outer, row inner), one per cycle; every
// 8th returned byte completes one word.
module search_block_fetch
  import me3drs_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  search_block_fetch_if.slave  bus
);

  state_t      state_r, state_s;

  logic [6:0]  bx_r;
  logic [5:0]  by_r;
  mv_t         mvx_r, mvy_r;
  logic [7:0]  rd_cnt_r;     // index of the next read to issue
  logic [7:0]  rx_cnt_r;     // index of the next byte to arrive
  logic [1:0]  drain_cnt_r;
  logic        rd_vld_r;     // mem_rdata carries a byte this cycle
  logic [55:0] shift_r;

  logic        mem_rd_en_r;
  logic [19:0] mem_addr_r;
  logic        data_we_r;
  logic [4:0]  data_addr_r;
  logic [63:0] data_out_r;
  logic        busy_r, done_r, err_r;

  logic        accept_s, legal_s, issue_s, busy_s, done_s, err_s;
  mv_t         mvx_in_s, mvy_in_s;
  logic [6:0]  src_bx_s;
  logic [5:0]  src_by_s;
  mv_t         src_mvx_s, src_mvy_s;
  logic [7:0]  src_idx_s;
  logic signed [CW-1:0] row_raw_s, col_raw_s;
  logic [CW-1:0] row_f_s, col_f_s;
  logic [19:0] row_ext_s;
  logic [19:0] addr_s;
  logic [63:0] word_s;

  // Request decode and address source selection. Read 0 is issued on
  // the accepting edge, so its address comes straight from the inputs.
  always_comb begin
    accept_s = bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    legal_s  = (bus.blk_x < 7'(BLKS_X)) && (bus.blk_y < 6'(BLKS_Y));
    if (bus.search_mode) begin
      mvx_in_s = clamp_mv(bus.mv_x);
      mvy_in_s = clamp_mv(bus.mv_y);
    end else begin
      mvx_in_s = 7'sd0;
      mvy_in_s = 7'sd0;
    end
    if (accept_s) begin
      src_bx_s  = bus.blk_x;
      src_by_s  = bus.blk_y;
      src_mvx_s = mvx_in_s;
      src_mvy_s = mvy_in_s;
      src_idx_s = 8'd0;
    end else begin
      src_bx_s  = bx_r;
      src_by_s  = by_r;
      src_mvx_s = mvx_r;
      src_mvy_s = mvy_r;
      src_idx_s = rd_cnt_r;
    end
    // idx = {column a, row c}
    row_raw_s = $signed({2'b00, src_by_s, src_idx_s[3:0]})
              + $signed({{5{src_mvy_s[6]}}, src_mvy_s});
    col_raw_s = $signed({1'b0, src_bx_s, src_idx_s[7:4]})
              + $signed({{5{src_mvx_s[6]}}, src_mvx_s});
  end

  mirror_fold #(.W(CW)) u_fold_row (
    .coord  (row_raw_s),
    .n      (12'(IMGHEIGHT)),
    .folded (row_f_s)
  );

  mirror_fold #(.W(CW)) u_fold_col (
    .coord  (col_raw_s),
    .n      (12'(IMGWIDTH)),
    .folded (col_f_s)
  );

  // row*1280 + col as shift-add; the sum lands in the mem_addr register
  always_comb begin
    row_ext_s = {8'd0, row_f_s};
    addr_s    = (row_ext_s << 10) + (row_ext_s << 8) + {8'd0, col_f_s};
    word_s    = {shift_r, bus.mem_rdata};
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state and next values of the status outputs. DONE also
  // accepts a new start so back-to-back requests lose no cycle.
  always_comb begin
    state_s = state_r;
    issue_s = 1'b0;
    err_s   = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          if (legal_s) begin
            state_s = ST_READ;
            issue_s = 1'b1;
          end else begin
            state_s = ST_DONE;
            err_s   = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        issue_s = 1'b1;
        if (rd_cnt_r == 8'd255) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        // memory latency, packing of the last byte, then done
        if (drain_cnt_r == 2'd2) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    done_s = (state_s == ST_DONE);
    busy_s = (state_s == ST_READ) || (state_s == ST_DRAIN);
  end

  // Request latch, read issue, byte packing and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      bx_r        <= 7'd0;
      by_r        <= 6'd0;
      mvx_r       <= 7'sd0;
      mvy_r       <= 7'sd0;
      rd_cnt_r    <= 8'd0;
      rx_cnt_r    <= 8'd0;
      drain_cnt_r <= 2'd0;
      rd_vld_r    <= 1'b0;
      shift_r     <= 56'd0;
      mem_rd_en_r <= 1'b0;
      mem_addr_r  <= 20'd0;
      data_we_r   <= 1'b0;
      data_addr_r <= 5'd0;
      data_out_r  <= 64'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      if (accept_s) begin
        bx_r  <= bus.blk_x;
        by_r  <= bus.blk_y;
        mvx_r <= mvx_in_s;
        mvy_r <= mvy_in_s;
      end
      if (accept_s) begin
        rd_cnt_r <= 8'd1;
      end else if (state_r == ST_READ) begin
        rd_cnt_r <= rd_cnt_r + 8'd1;
      end
      if (state_r == ST_DRAIN) begin
        drain_cnt_r <= drain_cnt_r + 2'd1;
      end else begin
        drain_cnt_r <= 2'd0;
      end

      mem_rd_en_r <= issue_s;
      if (issue_s) begin
        mem_addr_r <= addr_s;
      end
      rd_vld_r <= mem_rd_en_r;

      data_we_r <= 1'b0;
      if (rd_vld_r) begin
        shift_r  <= word_s[55:0];
        rx_cnt_r <= rx_cnt_r + 8'd1;
        if (rx_cnt_r[2:0] == 3'd7) begin
          data_we_r   <= 1'b1;
          data_out_r  <= word_s;
          data_addr_r <= make_data_addr(rx_cnt_r[7:4], rx_cnt_r[3]);
        end
      end else if (accept_s) begin
        rx_cnt_r <= 8'd0;
      end

      busy_r <= busy_s;
      done_r <= done_s;
      err_r  <= err_s;
    end
  end

  assign bus.mem_rd_en = mem_rd_en_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.data_we   = data_we_r;
  assign bus.data_addr = data_addr_r;
  assign bus.data_out  = data_out_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;

endmodule
